// File: rtl/ws_frame_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// ws_frame_scheduler_pkg
// Shared definitions for the WS2812 frame scheduler and its gap timer:
//   ws_state_e        - frame sequencer states (2-bit encoding)
//   WS_BITS_PER_PIX   - GRB word width sent to the serializer
//   COL_OFF_DEFAULT   - colour of a clear bit before any frame is captured
//   COL_ON_DEFAULT    - colour of a set bit before any frame is captured (dim green)
//   latch_cycles()    - converts the WS2812 latch time in us into clock cycles
// No ports (package).
// ----------------------------------------------------------------------------
package ws_frame_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } ws_state_e;

   localparam int WS_BITS_PER_PIX = 24;

   localparam logic [WS_BITS_PER_PIX-1:0] COL_OFF_DEFAULT = 24'h000000;
   localparam logic [WS_BITS_PER_PIX-1:0] COL_ON_DEFAULT  = 24'h200000;

   // Whole cycles per microsecond times the latch length; 720 at 12 MHz / 60 us.
   function automatic int latch_cycles(input int clk_hz, input int latch_us);
      return (clk_hz / 1_000_000) * latch_us;
   endfunction

endpackage

// File: rtl/ws_gap_timer.sv
// ----------------------------------------------------------------------------
// ws_gap_timer
// Down-counter used to hold the WS2812 data line idle for the latch gap.
// Loading sets the count to CYCLES; it then decrements once per clock and
// stops at zero (no underflow). done is high whenever the count is zero.
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous reset, active-low (count cleared to zero)
//   load   in  restart the gap; takes priority over counting
//   done   out count has reached zero
// ----------------------------------------------------------------------------
module ws_gap_timer #(
   parameter int CYCLES = 720
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic done
);

   localparam int CNT_W = $clog2(CYCLES + 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = CNT_W'(CYCLES);
      end else if (count_q != '0) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/ws_frame_scheduler.sv
// ----------------------------------------------------------------------------
// ws_frame_scheduler
// Sequences one WS2812 frame for the 4x4 binary-clock matrix. On a request it
// snapshots the four BCD digits and both colours, then hands 16 GRB words in
// chain order to the bit serializer over valid/ready, waits the latch gap and
// pulses frame_done. Requests arriving while busy coalesce into one more frame.
// Ports:
//   clk        in  system clock
//   rst_n      in  synchronous reset, active-low
//   start      in  frame request (level or pulse)
//   digits     in  {h1,h0,m1,m0}, 4 bits each
//   col_on     in  GRB colour for a set bit
//   col_off    in  GRB colour for a clear bit
//   px_data    out GRB word to the serializer, G7 first
//   px_valid   out px_data valid, held until px_ready
//   px_ready   in  serializer accepts the word on valid & ready
//   busy       out frame in progress, through the frame_done cycle
//   frame_done out one-cycle pulse after the latch gap
// ----------------------------------------------------------------------------
module ws_frame_scheduler
   import ws_frame_scheduler_pkg::*;
#(
   parameter int CLK_HZ     = 12_000_000,
   parameter int NUM_PIX    = 16,
   parameter int LATCH_US   = 60,
   parameter int SERPENTINE = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [15:0]                digits,
   input  logic [WS_BITS_PER_PIX-1:0] col_on,
   input  logic [WS_BITS_PER_PIX-1:0] col_off,
   output logic [WS_BITS_PER_PIX-1:0] px_data,
   output logic                       px_valid,
   input  logic                       px_ready,
   output logic                       busy,
   output logic                       frame_done
);

   // The column/row split of the index assumes a 4x4 matrix (NUM_PIX = 16).
   localparam int IDX_W     = 4;
   localparam int LATCH_CYC = latch_cycles(CLK_HZ, LATCH_US);

   ws_state_e                  state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic                       pending_q, pending_d;
   logic [15:0]                dig_q, dig_d;
   logic [WS_BITS_PER_PIX-1:0] on_q, on_d;
   logic [WS_BITS_PER_PIX-1:0] off_q, off_d;
   logic [WS_BITS_PER_PIX-1:0] px_data_q, px_data_d;
   logic                       px_valid_q, px_valid_d;
   logic                       busy_q, busy_d;
   logic                       frame_done_q, frame_done_d;
   logic                       start_frame;
   logic                       gap_load;
   logic                       gap_done;

   // Column c picks the digit (c=0 is h1, c=3 is m0). On serpentine wiring the
   // odd columns run bottom-to-top, so the bit order within them is reversed.
   function automatic logic [WS_BITS_PER_PIX-1:0] pixel_of(
      input logic [IDX_W-1:0]           idx,
      input logic [15:0]                dig,
      input logic [WS_BITS_PER_PIX-1:0] on,
      input logic [WS_BITS_PER_PIX-1:0] off
   );
      logic [1:0] col;
      logic [1:0] row;
      logic [1:0] bit_sel;
      logic [3:0] digit;
      col = idx[3:2];
      row = idx[1:0];
      case (col)
         2'd0:    digit = dig[15:12];
         2'd1:    digit = dig[11:8];
         2'd2:    digit = dig[7:4];
         default: digit = dig[3:0];
      endcase
      bit_sel = ((SERPENTINE != 0) && col[0]) ? (2'd3 - row) : row;
      return digit[bit_sel] ? on : off;
   endfunction

   ws_gap_timer #(
      .CYCLES (LATCH_CYC)
   ) u_gap_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (gap_load),
      .done  (gap_done)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      pending_d    = pending_q;
      dig_d        = dig_q;
      on_d         = on_q;
      off_d        = off_q;
      px_data_d    = px_data_q;
      px_valid_d   = px_valid_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      start_frame  = 1'b0;
      gap_load     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               start_frame = 1'b1;
            end
         end

         ST_SEND: begin
            if (start) begin
               pending_d = 1'b1;
            end
            // Next word is loaded on the accepting edge so valid never drops
            // between pixels.
            if (px_valid_q && px_ready) begin
               if (idx_q == IDX_W'(NUM_PIX - 1)) begin
                  px_valid_d = 1'b0;
                  gap_load   = 1'b1;
                  state_d    = ST_GAP;
               end else begin
                  idx_d     = idx_q + IDX_W'(1);
                  px_data_d = pixel_of(idx_q + IDX_W'(1), dig_q, on_q, off_q);
               end
            end
         end

         ST_GAP: begin
            if (start) begin
               pending_d = 1'b1;
            end
            if (gap_done) begin
               frame_done_d = 1'b1;
               state_d      = ST_DONE;
            end
         end

         default: begin
            // A request landing in the DONE cycle itself still earns a frame.
            if (pending_q || start) begin
               start_frame = 1'b1;
            end else begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
      endcase

      // Snapshot is taken from the live inputs, so pixel 0 uses them directly.
      if (start_frame) begin
         dig_d      = digits;
         on_d       = col_on;
         off_d      = col_off;
         idx_d      = '0;
         pending_d  = 1'b0;
         px_data_d  = pixel_of('0, digits, col_on, col_off);
         px_valid_d = 1'b1;
         busy_d     = 1'b1;
         state_d    = ST_SEND;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         pending_q    <= 1'b0;
         dig_q        <= '0;
         on_q         <= COL_ON_DEFAULT;
         off_q        <= COL_OFF_DEFAULT;
         px_data_q    <= '0;
         px_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         dig_q        <= dig_d;
         on_q         <= on_d;
         off_q        <= off_d;
         px_data_q    <= px_data_d;
         px_valid_q   <= px_valid_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign px_data    = px_data_q;
   assign px_valid   = px_valid_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws_frame_scheduler.sv
// ----------------------------------------------------------------------------
// tb_ws_frame_scheduler
// Drives two schedulers in lockstep (straight and serpentine wiring) from the
// same inputs and compares every word, stall, gap length and handshake edge
// against a pixel-list reference built from the matrix mapping rules.
// ----------------------------------------------------------------------------
module tb_ws_frame_scheduler;

   localparam int LATCH_CYC = 12 * 60;
   localparam int NUM_PIX   = 16;
   localparam int BUDGET    = 3000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] digits;
   logic [23:0] col_on;
   logic [23:0] col_off;
   logic        px_ready;

   logic [23:0] px_data0, px_data1;
   logic        px_valid0, px_valid1;
   logic        busy0, busy1;
   logic        frame_done0, frame_done1;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ws_frame_scheduler #(
      .CLK_HZ     (12_000_000),
      .NUM_PIX    (16),
      .LATCH_US   (60),
      .SERPENTINE (0)
   ) dut0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .digits     (digits),
      .col_on     (col_on),
      .col_off    (col_off),
      .px_data    (px_data0),
      .px_valid   (px_valid0),
      .px_ready   (px_ready),
      .busy       (busy0),
      .frame_done (frame_done0)
   );

   ws_frame_scheduler #(
      .CLK_HZ     (12_000_000),
      .NUM_PIX    (16),
      .LATCH_US   (60),
      .SERPENTINE (1)
   ) dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .digits     (digits),
      .col_on     (col_on),
      .col_off    (col_off),
      .px_data    (px_data1),
      .px_valid   (px_valid1),
      .px_ready   (px_ready),
      .busy       (busy1),
      .frame_done (frame_done1)
   );

   initial begin
      #600_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pixel p lights digit (p / 4) counted from h1, bit (p % 4), flipped on
   // odd columns when the chain snakes.
   function automatic logic [23:0] model_pixel(input int p, input logic [15:0] dig,
                                               input logic [23:0] on, input logic [23:0] off,
                                               input bit serp);
      int column;
      int row;
      int bitpos;
      int value;
      column = p / 4;
      row    = p % 4;
      value  = int'((dig >> (4 * (3 - column))) & 16'hF);
      bitpos = (serp && (column % 2 == 1)) ? 3 - row : row;
      return (((value >> bitpos) & 1) == 1) ? on : off;
   endfunction

   // Collects one frame that has just been started (valid visible now).
   task automatic collect(input string tag, input logic [15:0] dig, input logic [23:0] on,
                          input logic [23:0] off, input int ready_pct, input int change_at,
                          input logic [15:0] new_dig, input int gap_starts,
                          input bit check_timing, input bit expect_pending);
      logic [23:0] exp0 [NUM_PIX];
      logic [23:0] exp1 [NUM_PIX];
      logic [23:0] d0;
      logic [23:0] d1;
      logic        v0;
      int          n;
      int          edges;
      int          gap_cyc;
      int          starts_left;
      bit          busy_low;
      n           = 0;
      edges       = 0;
      gap_cyc     = 0;
      starts_left = gap_starts;
      busy_low    = 1'b0;
      for (int p = 0; p < NUM_PIX; p++) begin
         exp0[p] = model_pixel(p, dig, on, off, 1'b0);
         exp1[p] = model_pixel(p, dig, on, off, 1'b1);
      end
      check($sformatf("%s_first_valid", tag), {31'd0, px_valid0}, 32'd1);
      check($sformatf("%s_first_busy", tag), {31'd0, busy0}, 32'd1);

      while (n < NUM_PIX && edges < BUDGET) begin
         v0 = px_valid0;
         d0 = px_data0;
         d1 = px_data1;
         if (n == change_at) begin
            digits = new_dig;
         end
         px_ready = ($urandom_range(99) < ready_pct);
         tick();
         edges++;
         if (v0 && px_ready) begin
            check($sformatf("%s_word%0d_straight", tag, n), {8'd0, d0}, {8'd0, exp0[n]});
            check($sformatf("%s_word%0d_serp", tag, n), {8'd0, d1}, {8'd0, exp1[n]});
            n++;
         end else begin
            check($sformatf("%s_stall_valid", tag), {31'd0, px_valid0}, 32'd1);
            check($sformatf("%s_stall_data_straight", tag), {8'd0, px_data0}, {8'd0, d0});
            check($sformatf("%s_stall_data_serp", tag), {8'd0, px_data1}, {8'd0, d1});
         end
      end
      px_ready = 1'b1;
      check($sformatf("%s_word_count", tag), n, NUM_PIX);
      check($sformatf("%s_valid_after_last", tag), {30'd0, px_valid0, px_valid1}, 32'd0);

      while (!frame_done0 && edges < BUDGET) begin
         if (!busy0) begin
            busy_low = 1'b1;
         end
         if (starts_left > 0 && (gap_cyc == 5 || gap_cyc == 100 || gap_cyc == 300)) begin
            start = 1'b1;
            starts_left--;
         end
         tick();
         start = 1'b0;
         edges++;
         gap_cyc++;
      end
      check($sformatf("%s_done_seen", tag), {30'd0, frame_done0, frame_done1}, 32'd3);
      check($sformatf("%s_busy_at_done", tag), {31'd0, busy0}, 32'd1);
      check($sformatf("%s_busy_dropped_in_gap", tag), {31'd0, busy_low}, 32'd0);
      if (check_timing) begin
         check($sformatf("%s_frame_cycles", tag), edges, NUM_PIX + LATCH_CYC + 1);
      end

      tick();
      check($sformatf("%s_done_pulse_width", tag), {31'd0, frame_done0}, 32'd0);
      if (expect_pending) begin
         check($sformatf("%s_restart_valid", tag), {31'd0, px_valid0}, 32'd1);
         check($sformatf("%s_restart_busy", tag), {31'd0, busy0}, 32'd1);
      end else begin
         check($sformatf("%s_idle_busy", tag), {30'd0, busy0, busy1}, 32'd0);
         check($sformatf("%s_idle_valid", tag), {31'd0, px_valid0}, 32'd0);
      end
   endtask

   task automatic run_frame(input string tag, input logic [15:0] dig, input logic [23:0] on,
                            input logic [23:0] off, input int ready_pct, input int change_at,
                            input logic [15:0] new_dig, input int gap_starts,
                            input bit check_timing, input bit expect_pending);
      digits  = dig;
      col_on  = on;
      col_off = off;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      collect(tag, dig, on, off, ready_pct, change_at, new_dig, gap_starts,
              check_timing, expect_pending);
   endtask

   initial begin
      logic [15:0] rd;
      logic [23:0] ron;
      logic [23:0] roff;
      bit          done_seen;

      rst_n    = 1'b0;
      start    = 1'b0;
      px_ready = 1'b0;
      digits   = 16'h0000;
      col_on   = 24'hFF0000;
      col_off  = 24'h000000;
      tick();
      tick();
      tick();
      check("reset_px_data", {8'd0, px_data0}, 32'd0);
      check("reset_valid", {30'd0, px_valid0, px_valid1}, 32'd0);
      check("reset_busy", {30'd0, busy0, busy1}, 32'd0);
      check("reset_done", {30'd0, frame_done0, frame_done1}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Reset asserted in the middle of a frame.
      digits = 16'h5A3C;
      start  = 1'b1;
      tick();
      start    = 1'b0;
      px_ready = 1'b1;
      tick();
      tick();
      tick();
      rst_n     = 1'b0;
      done_seen = 1'b0;
      tick();
      check("midreset_valid", {30'd0, px_valid0, px_valid1}, 32'd0);
      check("midreset_busy", {30'd0, busy0, busy1}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         if (frame_done0 || frame_done1) begin
            done_seen = 1'b1;
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < LATCH_CYC + 40; i++) begin
         tick();
         if (frame_done0 || frame_done1 || busy0) begin
            done_seen = 1'b1;
         end
      end
      check("midreset_no_done_or_busy", {31'd0, done_seen}, 32'd0);

      run_frame("full", 16'h1234, 24'hFF0000, 24'h000000, 100, -1, 16'h0, 0, 1'b1, 1'b0);
      run_frame("serp", 16'h0100, 24'hFF0000, 24'h000000, 100, -1, 16'h0, 0, 1'b1, 1'b0);
      run_frame("bp", 16'h1234, 24'hFF0000, 24'h000000, 30, -1, 16'h0, 0, 1'b0, 1'b0);
      run_frame("snap0", 16'h0000, 24'hFF0000, 24'h000000, 100, 5, 16'hFFFF, 0, 1'b1, 1'b0);
      run_frame("snap1", 16'hFFFF, 24'hFF0000, 24'h000000, 100, -1, 16'h0, 0, 1'b1, 1'b0);

      // Three requests during the gap coalesce into one frame using the
      // digits present at the DONE edge.
      run_frame("coal0", 16'h1234, 24'h00FF00, 24'h000011, 100, 5, 16'h2359, 3, 1'b1, 1'b1);
      collect("coal1", 16'h2359, 24'h00FF00, 24'h000011, 100, -1, 16'h0, 0, 1'b1, 1'b0);

      for (int k = 0; k < 3; k++) begin
         rd   = 16'($urandom);
         ron  = 24'($urandom);
         roff = 24'($urandom);
         run_frame($sformatf("rand%0d", k), rd, ron, roff, 30, -1, 16'h0, 0, 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
